wav_stream_parser: RTL and testbench
====================================

WAV_STREAM_PARSER -- requirements
Module: wav_stream_parser

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of interleaved channels per frame (1..8).
REQ-002 SHALL have parameter SAMPLE_BYTES, default 2, bytes per PCM sample (1..3).
REQ-003 SHALL have parameter OUT_W, default 24, output sample width; OUT_W >= 8*SAMPLE_BYTES.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin parsing a new stream.
REQ-007 SHALL have port byte_in  input  8  little-endian WAV byte stream.
REQ-008 SHALL have port byte_valid  input  1  byte_in valid.
REQ-009 SHALL have port byte_ready  output  1  parser accepts byte_in.
REQ-010 SHALL have port frame_data  output  NUM_CH*OUT_W  channel 0 in LSBs, unsigned offset-binary.
REQ-011 SHALL have port frame_valid  output  1  frame_data valid.
REQ-012 SHALL have port frame_ready  input  1  downstream accepts frame.
REQ-013 SHALL have port num_frames  output  32  frame count decoded from data size.
REQ-014 SHALL have port done  output  1  all frames delivered.
REQ-015 SHALL have port error  output  1  header check failed.

Function
REQ-016 SHALL accept a byte only when byte_valid && byte_ready; byte_ready=1 only in HDR, SIZE, DATA.
REQ-017 SHALL implement states IDLE, HDR, SIZE, DATA, OUT, DONE, ERR.
REQ-018 IDLE/DONE/ERR: start=1 -> HDR, clearing byte/channel/frame counters, done and error; start ignored in other states.
REQ-019 HDR: consume exactly 40 bytes (offsets 0..39), then -> SIZE.
REQ-020 SIZE: consume 4 bytes, LSB first, as data size; num_frames = size / (NUM_CH*SAMPLE_BYTES), truncating; num_frames=0 -> DONE, else DATA.
REQ-021 DATA: assemble SAMPLE_BYTES bytes per sample, NUM_CH samples per frame; after the last byte of a frame is accepted, -> OUT next cycle with frame_valid=1.
REQ-022 OUT: frame_valid and frame_data held stable until frame_ready=1; on handshake -> DONE if the delivered count equals num_frames, else DATA.
REQ-023 Conversion: SAMPLE_BYTES>1 -> sample MSB inverted (signed to offset-binary); SAMPLE_BYTES=1 -> passed unchanged (8-bit WAV is unsigned).
REQ-024 Alignment: converted sample MSB-aligned in OUT_W, LSBs zero-filled.
REQ-025 Remainder bytes (size not a multiple of frame bytes) SHALL NOT be consumed; byte_ready=0 in DONE.
REQ-026 done SHALL be 1 in DONE only; throughput one byte per cycle plus one OUT cycle per frame minimum.

Reset
REQ-027 rst SHALL force IDLE; byte_ready=0, frame_valid=0, done=0, error=0, num_frames=0, every frame_data channel = midscale (1 << (OUT_W-1)).
REQ-028 rst mid-operation SHALL discard the partial frame; next start parses a fresh stream.

Configuration
REQ-029 Macro WAV_PARSER_HDR_CHECK_EN defined: HDR compares offsets 0-3 to "RIFF" (52 49 46 46), 8-11 to "WAVE" (57 41 56 45), 36-39 to "data" (64 61 74 61); any mismatch -> ERR after byte 39, error=1, byte_ready=0, until start or rst.
REQ-030 Macro undefined: header contents ignored, ERR unreachable, error tied 0.

Structure
REQ-031 Package wav_pkg SHALL hold state enum typedef, HDR_LEN=40, SIZE_LEN=4, tag constants.
REQ-032 Sub-module wav_sample_conv SHALL implement REQ-023/024 combinationally, instanced per channel.

Verification
REQ-033 2ch/16b/OUT_W=24, valid header, size=8, data 00 80 FF 7F 34 12 00 00 -> frames {ch0=000000, ch1=FFFF00}, {ch0=923400, ch1=800000}; num_frames=2; done=1 after second handshake.
REQ-034 frame_ready held 0 for 5 cycles in OUT -> frame_valid=1, frame_data stable, byte_ready=0 throughout.
REQ-035 size=0 -> DONE one cycle after 4th size byte, frame_valid never asserted.
REQ-036 size=7 (2ch/16b) -> num_frames=1, one frame, done=1, trailing 3 bytes not accepted; SAMPLE_BYTES=1 byte 80 -> 800000.
REQ-037 rst asserted mid-DATA -> IDLE, frame_data midscale; new start with fresh stream -> correct frames.
REQ-038 With WAV_PARSER_HDR_CHECK_EN, header "RIFX" -> error=1 after byte 39, no frames; without macro same stream parses normally.

Source files
------------

// File: rtl/wav_pkg.sv
// Shared types and constants for the WAV stream parser: FSM states, header/size lengths
// and the RIFF/WAVE/data tag bytes used when WAV_PARSER_HDR_CHECK_EN is defined.
package wav_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SIZE,
        ST_DATA,
        ST_OUT,
        ST_DONE,
        ST_ERR
    } wav_state_e;

    localparam int HDR_LEN  = 40;
    localparam int SIZE_LEN = 4;

    // Tags written in stream order: byte at offset N+0 sits in bits [31:24].
    localparam logic [31:0] TAG_RIFF = 32'h5249_4646;
    localparam logic [31:0] TAG_WAVE = 32'h5741_5645;
    localparam logic [31:0] TAG_DATA = 32'h6461_7461;

    function automatic logic hdr_mismatch(input logic [5:0] off, input logic [7:0] b);
        logic [31:0] tag;
        logic        chk;
        logic [7:0]  exp_b;
        tag = '0;
        chk = 1'b0;
        if (off < 6'd4) begin
            tag = TAG_RIFF;
            chk = 1'b1;
        end else if (off >= 6'd8 && off < 6'd12) begin
            tag = TAG_WAVE;
            chk = 1'b1;
        end else if (off >= 6'd36 && off < 6'd40) begin
            tag = TAG_DATA;
            chk = 1'b1;
        end
        case (off[1:0])
            2'd0:    exp_b = tag[31:24];
            2'd1:    exp_b = tag[23:16];
            2'd2:    exp_b = tag[15:8];
            default: exp_b = tag[7:0];
        endcase
        return chk && (b != exp_b);
    endfunction

endpackage

// File: rtl/wav_sample_conv.sv
// Converts one little-endian PCM sample to offset-binary and MSB-aligns it in OUT_W bits.
// Multi-byte WAV samples are two's complement; 8-bit WAV samples are already unsigned.
module wav_sample_conv #(
    parameter int SAMPLE_BYTES = 2,
    parameter int OUT_W        = 24
) (
    input  logic [8*SAMPLE_BYTES-1:0] raw,
    output logic [OUT_W-1:0]          sample
);

    localparam int SW = 8 * SAMPLE_BYTES;

    logic [SW-1:0] offset_bin;

    generate
        if (SAMPLE_BYTES > 1) begin : g_signed
            assign offset_bin = raw ^ {1'b1, {(SW-1){1'b0}}};
        end else begin : g_unsigned
            assign offset_bin = raw;
        end
    endgenerate

    assign sample = OUT_W'(offset_bin) << (OUT_W - SW);

endmodule

// File: rtl/wav_stream_parser.sv
// Parses a canonical 44-byte-header WAV byte stream into interleaved PCM frames.
// Define WAV_PARSER_HDR_CHECK_EN to verify the RIFF/WAVE/data tags and flag mismatches.
module wav_stream_parser
    import wav_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int SAMPLE_BYTES = 2,
    parameter int OUT_W        = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic [NUM_CH*OUT_W-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [31:0]             num_frames,
    output logic                    done,
    output logic                    error
);

    localparam int SW          = 8 * SAMPLE_BYTES;
    localparam int FRAME_BYTES = NUM_CH * SAMPLE_BYTES;
    localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

    wav_state_e state, state_nxt;

    logic [5:0]  byte_cnt;
    logic [1:0]  smp_byte;
    logic [2:0]  ch_idx;
    logic [23:0] size_lo;
    logic [31:0] frame_cnt;
    logic [31:0] size_full;
    logic [31:0] frames_calc;
    logic        accept;
    logic        start_ok;
    logic        data_take;
    logic        last_smp_byte;
    logic        last_ch;
    logic        frame_end;
    logic        hdr_fail;

    logic [SW-1:0]           raw     [NUM_CH];
    logic [SW-1:0]           raw_nxt [NUM_CH];
    logic [NUM_CH*OUT_W-1:0] conv_flat;

    assign accept        = byte_valid && byte_ready;
    assign start_ok      = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign data_take     = accept && (state == ST_DATA);
    assign last_smp_byte = (smp_byte == 2'(SAMPLE_BYTES - 1));
    assign last_ch       = (ch_idx == 3'(NUM_CH - 1));
    assign frame_end     = data_take && last_smp_byte && last_ch;
    assign size_full     = {byte_in, size_lo};
    assign frames_calc   = size_full / 32'(FRAME_BYTES);

`ifdef WAV_PARSER_HDR_CHECK_EN
    logic hdr_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_bad <= 1'b0;
        end else if (start_ok) begin
            hdr_bad <= 1'b0;
        end else if (state == ST_HDR && accept && hdr_mismatch(byte_cnt, byte_in)) begin
            hdr_bad <= 1'b1;
        end
    end

    // The final header byte is checked in the same cycle it is consumed.
    assign hdr_fail = hdr_bad || hdr_mismatch(byte_cnt, byte_in);
    assign error    = (state == ST_ERR);
`else
    assign hdr_fail = 1'b0;
    assign error    = 1'b0;
`endif

    assign byte_ready  = (state == ST_HDR) || (state == ST_SIZE) || (state == ST_DATA);
    assign frame_valid = (state == ST_OUT);
    assign done        = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (accept && byte_cnt == 6'(HDR_LEN - 1)) state_nxt = hdr_fail ? ST_ERR : ST_SIZE;
            end
            ST_SIZE: begin
                if (accept && byte_cnt == 6'(SIZE_LEN - 1))
                    state_nxt = (frames_calc == 32'd0) ? ST_DONE : ST_DATA;
            end
            ST_DATA: begin
                if (frame_end) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (frame_ready) state_nxt = (frame_cnt + 32'd1 == num_frames) ? ST_DONE : ST_DATA;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            smp_byte   <= '0;
            ch_idx     <= '0;
            size_lo    <= '0;
            frame_cnt  <= '0;
            num_frames <= '0;
            frame_data <= {NUM_CH{MIDSCALE}};
        end else if (start_ok) begin
            byte_cnt   <= '0;
            smp_byte   <= '0;
            ch_idx     <= '0;
            frame_cnt  <= '0;
            num_frames <= '0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (accept) byte_cnt <= (byte_cnt == 6'(HDR_LEN - 1)) ? 6'd0 : byte_cnt + 6'd1;
                end
                ST_SIZE: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 6'd1;
                        size_lo  <= {byte_in, size_lo[23:8]};
                        if (byte_cnt == 6'(SIZE_LEN - 1)) num_frames <= frames_calc;
                    end
                end
                ST_DATA: begin
                    if (data_take) begin
                        if (last_smp_byte) begin
                            smp_byte <= 2'd0;
                            ch_idx   <= last_ch ? 3'd0 : ch_idx + 3'd1;
                        end else begin
                            smp_byte <= smp_byte + 2'd1;
                        end
                    end
                    if (frame_end) frame_data <= conv_flat;
                end
                ST_OUT: begin
                    if (frame_ready) frame_cnt <= frame_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Sample assembly buffer; its contents only matter once a full frame has been written.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            raw_nxt[c] = raw[c];
            for (int k = 0; k < SAMPLE_BYTES; k++) begin
                if (data_take && ch_idx == 3'(c) && smp_byte == 2'(k))
                    raw_nxt[c][8*k +: 8] = byte_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        raw <= raw_nxt;
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_conv
            wav_sample_conv #(
                .SAMPLE_BYTES(SAMPLE_BYTES),
                .OUT_W       (OUT_W)
            ) u_conv (
                .raw   (raw_nxt[c]),
                .sample(conv_flat[c*OUT_W +: OUT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_wav_stream_parser.sv
// Self-checking bench for wav_stream_parser: directed streams plus randomized streams
// checked against a sample-value model; a mono 8-bit instance covers unsigned samples.
module tb_wav_stream_parser;

    localparam int NUM_CH       = 2;
    localparam int SAMPLE_BYTES = 2;
    localparam int OUT_W        = 24;
    localparam logic [47:0] MID2 = 48'h800000_800000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, byte_valid, frame_ready;
    logic [7:0]  byte_in;
    logic        byte_ready, frame_valid, done, error;
    logic [47:0] frame_data;
    logic [31:0] num_frames;

    logic        start8, byte_valid8, frame_ready8;
    logic [7:0]  byte_in8;
    logic        byte_ready8, frame_valid8, done8, error8;
    logic [23:0] frame_data8;
    logic [31:0] num_frames8;

    int checks = 0;
    int errors = 0;

    logic [7:0]  data_q[$];
    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    wav_stream_parser #(.NUM_CH(NUM_CH), .SAMPLE_BYTES(SAMPLE_BYTES), .OUT_W(OUT_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .num_frames(num_frames), .done(done), .error(error)
    );

    wav_stream_parser #(.NUM_CH(1), .SAMPLE_BYTES(1), .OUT_W(24)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .byte_in(byte_in8), .byte_valid(byte_valid8),
        .byte_ready(byte_ready8), .frame_data(frame_data8), .frame_valid(frame_valid8),
        .frame_ready(frame_ready8), .num_frames(num_frames8), .done(done8), .error(error8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? byte_ready8 : byte_ready;
    endfunction

    task automatic push_byte(input bit sel, input logic [7:0] b);
        int n;
        n = 0;
        if (sel) begin byte_in8 = b; byte_valid8 = 1'b1; end
        else     begin byte_in  = b; byte_valid  = 1'b1; end
        while (!rdy(sel) && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept_wait", 64'(n < 64), 1);
        @(negedge clk);
        byte_valid  = 1'b0;
        byte_valid8 = 1'b0;
    endtask

    function automatic logic [7:0] hdr_byte(input int i, input bit bad);
        case (i)
            0:  return 8'h52;
            1:  return 8'h49;
            2:  return 8'h46;
            3:  return bad ? 8'h58 : 8'h46;
            8:  return 8'h57;
            9:  return 8'h41;
            10: return 8'h56;
            11: return 8'h45;
            36: return 8'h64;
            37: return 8'h61;
            38: return 8'h74;
            39: return 8'h61;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic send_header(input bit sel, input bit bad);
        for (int i = 0; i < 40; i++) push_byte(sel, hdr_byte(i, bad));
    endtask

    // Expected frame: each channel's signed 16-bit value offset by +32768, then scaled to 24 bits.
    function automatic logic [47:0] model_frame(input int f);
        logic [47:0]        r;
        logic signed [15:0] sv;
        int                 s;
        longint             u;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sv = {data_q[f*4 + c*2 + 1], data_q[f*4 + c*2]};
            s  = sv;
            u  = longint'(s + 32768) * 256;
            r[c*24 +: 24] = u[23:0];
        end
        return r;
    endfunction

    task automatic recv_frame(input logic [47:0] e, input int stall);
        int n;
        n = 0;
        while (!frame_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait", 64'(n < 64), 1);
        check("frame_data", frame_data, e);
        check("out_byte_ready", byte_ready, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", frame_valid, 1);
            check("stall_data", frame_data, e);
            check("stall_byte_ready", byte_ready, 0);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_stream(input logic [31:0] size, input int stall_first, input int stall_max,
                              input bit preset, input bit bad_hdr);
        int          frames;
        logic [47:0] e;
        frames = int'(size / 4);
        if (!preset) begin
            data_q.delete();
            for (int i = 0; i < int'(size); i++) data_q.push_back(8'($urandom));
        end
        do_start();
        check("start_clears_done", done, 0);
        check("start_clears_error", error, 0);
        send_header(1'b0, bad_hdr);
`ifdef WAV_PARSER_HDR_CHECK_EN
        if (bad_hdr) begin
            check("hdr_error", error, 1);
            check("hdr_error_byte_ready", byte_ready, 0);
            repeat (3) @(negedge clk);
            check("hdr_error_hold", {error, frame_valid, byte_ready, done}, 4'b1000);
            return;
        end
`endif
        for (int i = 0; i < 4; i++) push_byte(1'b0, size[8*i +: 8]);
        check("num_frames", num_frames, size / 4);
        for (int f = 0; f < frames; f++) begin
            for (int b = 0; b < 4; b++) push_byte(1'b0, data_q[f*4 + b]);
            check("frame_latency", frame_valid, 1);
            e = preset ? exp_q[f] : model_frame(f);
            recv_frame(e, (f == 0) ? stall_first : int'($urandom_range(0, stall_max)));
        end
        check("done", done, 1);
        check("done_frame_valid", frame_valid, 0);
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check("remainder_blocked", byte_ready, 0);
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] b8;
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; frame_ready = 1'b0;
        start8 = 1'b0; byte_valid8 = 1'b0; byte_in8 = 8'h00; frame_ready8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_num_frames", num_frames, 0);
        check("rst_frame_data", frame_data, MID2);
        rst = 1'b0;
        @(negedge clk);
        check("idle_byte_ready", byte_ready, 0);

        // Known two-frame stream, first frame held 5 cycles.
        data_q = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'h34, 8'h12, 8'h00, 8'h00};
        exp_q  = '{48'hFFFF00_000000, 48'h800000_923400};
        run_stream(32'd8, 5, 0, 1'b1, 1'b0);
        check("known_num_frames", num_frames, 2);

        run_stream(32'd0, 0, 0, 1'b0, 1'b0);
        run_stream(32'd7, 0, 2, 1'b0, 1'b0);

        // Reset in the middle of a frame.
        do_start();
        send_header(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_byte(1'b0, (i == 0) ? 8'd8 : 8'd0);
        for (int i = 0; i < 3; i++) push_byte(1'b0, 8'($urandom));
        rst = 1'b1;
        #1;
        check("midrst_frame_data", frame_data, MID2);
        check("midrst_byte_ready", byte_ready, 0);
        check("midrst_num_frames", num_frames, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_stream(32'd8, 1, 2, 1'b0, 1'b0);

        for (int t = 0; t < 4; t++) run_stream(32'($urandom_range(0, 26)), 0, 3, 1'b0, 1'b0);

        run_stream(32'd4, 0, 0, 1'b0, 1'b1);
        do_start();
        check("restart_clears_error", error, 0);

        // Mono 8-bit instance: unsigned samples pass through unchanged.
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        send_header(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_byte(1'b1, (i == 0) ? 8'd2 : 8'd0);
        check("u8_num_frames", num_frames8, 2);
        push_byte(1'b1, 8'h80);
        check("u8_frame_valid", frame_valid8, 1);
        check("u8_frame_mid", frame_data8, 24'h800000);
        frame_ready8 = 1'b1;
        @(negedge clk);
        frame_ready8 = 1'b0;
        b8 = 8'($urandom);
        push_byte(1'b1, b8);
        check("u8_frame_rand", frame_data8, (32'(b8) * 32'd65536) & 32'hFFFFFF);
        frame_ready8 = 1'b1;
        @(negedge clk);
        frame_ready8 = 1'b0;
        check("u8_done", done8, 1);
        check("u8_error", error8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
